// File: rtl/cla16_aor_enc32.sv
// Logic-locked 16-bit two-level carry-lookahead adder with a registered 17-bit sum.
// Define CLA16_LOCK_EN to insert the 32 AND/OR key gates on the generate/propagate nets.
module cla16_aor_enc32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] add1_i,
    input  logic [15:0] add2_i,
    input  logic [31:0] keyinput,
    output logic [16:0] result_o
);

    logic [15:0] g_raw;
    logic [15:0] p_raw;
    logic [15:0] g_lk;
    logic [15:0] p_lk;
    logic [16:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [16:0] sum_next;

    assign g_raw = add1_i & add2_i;
    assign p_raw = add1_i ^ add2_i;

`ifdef CLA16_LOCK_EN
    localparam logic [31:0] UNLOCK_KEY = 32'hD7D41D23;
    localparam logic [15:0] KEY_G      = UNLOCK_KEY[15:0];
    localparam logic [15:0] KEY_P      = UNLOCK_KEY[31:16];

    // Where the correct bit is 1 the gate is n & k; where it is 0 it is n | k.
    assign g_lk = (g_raw & (keyinput[15:0]  | ~KEY_G)) | (keyinput[15:0]  & ~KEY_G);
    assign p_lk = (p_raw & (keyinput[31:16] | ~KEY_P)) | (keyinput[31:16] & ~KEY_P);
`else
    logic unused_key;

    assign unused_key = ^keyinput;
    assign g_lk       = g_raw;
    assign p_lk       = p_raw;
`endif

    // First level: group generate/propagate per 4-bit group.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grp_g = '0;
        grp_p = '0;
        for (int j = 0; j < 4; j++) begin
            grp_g[j] = g_lk[4*j+3]
                     | (p_lk[4*j+3] & g_lk[4*j+2])
                     | (p_lk[4*j+3] & p_lk[4*j+2] & g_lk[4*j+1])
                     | (p_lk[4*j+3] & p_lk[4*j+2] & p_lk[4*j+1] & g_lk[4*j]);
            grp_p[j] = &p_lk[4*j +: 4];
        end
    end

    // Second level plus in-group lookahead; c[0] is tied low since there is no carry-in.
    always_comb begin
        c     = '0;
        c[4]  = grp_g[0];
        c[8]  = grp_g[1] | (grp_p[1] & grp_g[0]);
        c[12] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0]);
        c[16] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
              | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
        for (int j = 0; j < 4; j++) begin
            c[4*j+1] = g_lk[4*j] | (p_lk[4*j] & c[4*j]);
            c[4*j+2] = g_lk[4*j+1] | (p_lk[4*j+1] & g_lk[4*j])
                     | (p_lk[4*j+1] & p_lk[4*j] & c[4*j]);
            c[4*j+3] = g_lk[4*j+2] | (p_lk[4*j+2] & g_lk[4*j+1])
                     | (p_lk[4*j+2] & p_lk[4*j+1] & g_lk[4*j])
                     | (p_lk[4*j+2] & p_lk[4*j+1] & p_lk[4*j] & c[4*j]);
        end
    end

    assign sum_next = {c[16], p_lk ^ c[15:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) result_o <= '0;
        else         result_o <= sum_next;
    end

endmodule

// File: tb/tb_cla16_aor_enc32.sv
// Self-checking bench for cla16_aor_enc32: directed vector table, key/reset sequences
// and randomized operands/keys checked against a bit-serial reference model.
module tb_cla16_aor_enc32;

    localparam logic [31:0] GOOD_KEY = 32'hD7D41D23;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] add1_i;
    logic [15:0] add2_i;
    logic [31:0] keyinput;
    logic [16:0] result_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] exp;
    } vec_t;

    cla16_aor_enc32 dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .add1_i   (add1_i),
        .add2_i   (add2_i),
        .keyinput (keyinput),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    // Locked nets fed through a plain ripple recurrence; unlocked builds are just a + b.
    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic [31:0] key);
        logic [16:0] r;
`ifdef CLA16_LOCK_EN
        logic carry;
        logic gi;
        logic pi;
        carry = 1'b0;
        r     = '0;
        for (int i = 0; i < 16; i++) begin
            gi = a[i] & b[i];
            pi = a[i] ^ b[i];
            gi = GOOD_KEY[i]    ? (gi & key[i])    : (gi | key[i]);
            pi = GOOD_KEY[16+i] ? (pi & key[16+i]) : (pi | key[16+i]);
            r[i]  = pi ^ carry;
            carry = gi | (pi & carry);
        end
        r[16] = carry;
`else
        r = 17'(a) + 17'(b);
        if (key == 32'hFFFF_FFFF) r = r; // key has no effect in this build
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [31:0] k);
        add1_i   = a;
        add2_i   = b;
        keyinput = k;
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] rk;

        vecs[0] = '{16'h8943, 16'hFFFF, 17'h18942};
        vecs[1] = '{16'h5555, 16'hAAAA, 17'h0FFFF};
        vecs[2] = '{16'hFADC, 16'h00DC, 17'h0FBB8};
        vecs[3] = '{16'h0000, 16'h0001, 17'h00001};
        vecs[4] = '{16'h1111, 16'hEEAA, 17'h0FFBB};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};

        // Reset holds output low across edges regardless of inputs.
        rst_ni = 1'b0;
        drive(16'hFFFF, 16'hFFFF, GOOD_KEY);
        #2;
        check("reset_async", result_o, 17'h00000);
        step();
        step();
        check("reset_held", result_o, 17'h00000);

        drive(16'h29AF, 16'h7A1B, GOOD_KEY);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("release_no_edge", result_o, 17'h00000);
        step();
        check("first_capture", result_o, 17'h0A3CA);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, GOOD_KEY);
            step();
            check($sformatf("vec%0d", i), result_o, vecs[i].exp);
        end

        // Wrong AND-type key bit (g[5]), then correcting the key on the fly.
        drive(16'h0020, 16'h0020, 32'hD7D41D03);
        step();
`ifdef CLA16_LOCK_EN
        check("wrong_and_key", result_o, 17'h00000);
`else
        check("wrong_and_key", result_o, 17'h00040);
`endif
        keyinput = GOOD_KEY;
        step();
        check("key_fixed", result_o, 17'h00040);

        // Wrong OR-type key bit (p[0]).
        drive(16'h0000, 16'h0000, 32'hD7D51D23);
        step();
`ifdef CLA16_LOCK_EN
        check("wrong_or_key", result_o, 17'h00001);
`else
        check("wrong_or_key", result_o, 17'h00000);
`endif

        // Unlocked-reference vector: true sum only guaranteed without locking.
        drive(16'h1024, 16'h8192, 32'h0000_0000);
        step();
`ifdef CLA16_LOCK_EN
        check("zero_key", result_o, ref_sum(16'h1024, 16'h8192, 32'h0));
`else
        check("zero_key", result_o, 17'h091B6);
`endif

        // Mid-cycle async reset discards the in-flight sum.
        drive(16'h1234, 16'h4321, GOOD_KEY);
        step();
        check("pre_pulse", result_o, 17'h05555);
        drive(16'hFFFF, 16'h0001, GOOD_KEY);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_pulse", result_o, 17'h00000);
        #1;
        rst_ni = 1'b1;
        #1;
        check("pulse_released", result_o, 17'h00000);
        step();
        check("post_pulse", result_o, 17'h10000);

        // Inputs wiggle between edges; only the settled value is captured.
        drive(16'hAAAA, 16'h1111, GOOD_KEY);
        #2;
        drive(16'h0F0F, 16'h00F1, GOOD_KEY);
        step();
        check("settled_capture", result_o, 17'h01000);

        // Random operands, mostly with the correct key, sometimes with a disturbed one.
        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rk = 32'($urandom);
                1:       rk = GOOD_KEY ^ (32'h1 << $urandom_range(0, 31));
                default: rk = GOOD_KEY;
            endcase
            drive(ra, rb, rk);
            step();
            check($sformatf("rand%0d", n), result_o, ref_sum(ra, rb, rk));
            if (rk == GOOD_KEY) check($sformatf("rand_true%0d", n), result_o, 17'(ra) + 17'(rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
